// File: rtl/fwd_hazard_unit_if.sv
// Forwarding / hazard handshake bundle between pipeline control and fwd_hazard_unit.
// master = pipeline side, slave = hazard unit.
interface fwd_hazard_unit_if #(
  parameter int REG_AW = 5,
  parameter int SELW   = 2
);
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_valid;
  logic [REG_AW-1:0] ex_rs;
  logic [REG_AW-1:0] ex_rt;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_regwrite;
  logic              ex_memread;
  logic              flush;
  logic [SELW-1:0]   forward_a;
  logic [SELW-1:0]   forward_b;
  logic              stall;
  logic              bubble;
  logic [31:0]       stall_count;

  modport master (
    output id_rs, id_rt, id_valid,
    output ex_rs, ex_rt, ex_rd,
    output ex_regwrite, ex_memread, flush,
    input  forward_a, forward_b,
    input  stall, bubble, stall_count
  );

  modport slave (
    input  id_rs, id_rt, id_valid,
    input  ex_rs, ex_rt, ex_rd,
    input  ex_regwrite, ex_memread, flush,
    output forward_a, forward_b,
    output stall, bubble, stall_count
  );
endinterface

// File: rtl/fwd_hazard_unit.sv
// Forwarding select and multi-cycle load-use stall unit with shadow pipeline.
// Optional stall statistics counter: define HAZARD_STATS_EN.
module fwd_hazard_unit #(
  parameter int REG_AW   = 5,
  parameter int DEPTH    = 2,
  parameter int LOAD_LAT = 1,
  parameter int SELW     = $clog2(DEPTH+1)
) (
  input  logic clk,
  input  logic rst,
  fwd_hazard_unit_if.slave bus
);
  localparam int CW = $clog2(LOAD_LAT+1);

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic              wr;
    logic              ld;
  } ent_t;

  typedef enum logic {IDLE, STALL} state_t;

  ent_t            sh [1:DEPTH];
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_nxt;
  state_t          state;
  logic            detect;
  logic            stall_w;
  logic [SELW-1:0] fa;
  logic [SELW-1:0] fb;

  // Shift is unconditional: a stall injects a bubble into EX.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 1; k <= DEPTH; k++)
        sh[k] <= '0;
    end else begin
      sh[1] <= '{bus.ex_rd, bus.ex_regwrite,
                 bus.ex_memread};
      for (int k = 2; k <= DEPTH; k++)
        sh[k] <= sh[k-1];
    end
  end

  // Scan oldest to youngest so the youngest match wins.
  always_comb begin
    fa = '0;
    fb = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (sh[k].wr && sh[k].rd != '0 &&
          (!sh[k].ld || k >= LOAD_LAT+1)) begin
        if (sh[k].rd == bus.ex_rs) fa = SELW'(k);
        if (sh[k].rd == bus.ex_rt) fb = SELW'(k);
      end
    end
  end

  assign detect = bus.id_valid
               && bus.ex_memread
               && bus.ex_regwrite
               && bus.ex_rd != '0
               && (bus.ex_rd == bus.id_rs
                || bus.ex_rd == bus.id_rt);

  assign state = (cnt != '0) ? STALL : IDLE;

  assign stall_w = !bus.flush
                && (state == STALL || detect);

  always_comb begin
    cnt_nxt = '0;
    priority case (1'b1)
      bus.flush:        cnt_nxt = '0;
      (state == STALL): cnt_nxt = cnt - CW'(1);
      detect:           cnt_nxt = CW'(LOAD_LAT-1);
      default:          cnt_nxt = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= '0;
    else     cnt <= cnt_nxt;
  end

`ifdef HAZARD_STATS_EN
  logic [31:0] scnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      scnt <= '0;
    else if (stall_w && scnt != '1)
      scnt <= scnt + 32'd1;
  end

  assign bus.stall_count = scnt;
`else
  assign bus.stall_count = '0;
`endif

  assign bus.forward_a = fa;
  assign bus.forward_b = fb;
  assign bus.stall     = stall_w;
  assign bus.bubble    = stall_w;
endmodule
